// File: rtl/seg7_reader_if.sv
// Event handshake between the segment-bus reader and its consumer.
// The reader drives EV_VALID/EV_DATA; the consumer answers with EV_READY.
interface seg7_reader_if;
    logic       EV_VALID;
    logic [5:0] EV_DATA;
    logic       EV_READY;

    modport master (
        output EV_VALID,
        output EV_DATA,
        input  EV_READY
    );

    modport slave (
        input  EV_VALID,
        input  EV_DATA,
        output EV_READY
    );
endinterface

// File: rtl/seg7_reader.sv
// Samples an active-low 7-segment bus, filters it for stability and decodes
// each settled pattern to a hex digit, blank or illegal, reporting changes as events.
module seg7_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic [6:0]        HEX_IN,
    output logic [3:0]        VALUE,
    output logic              DIG_VALID,
    output logic              BLANK,
    output logic              ERR,
    output logic              OVF,
    input  logic              CLR_OVF,
    seg7_reader_if.master     ev
);
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;
    localparam logic [CNT_W-1:0] TC_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TC_PRE    = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [1:0]       KIND_DIG  = 2'b00;
    localparam logic [1:0]       KIND_BLK  = 2'b01;
    localparam logic [1:0]       KIND_ILL  = 2'b10;

    logic [6:0]       r_sync1;
    logic [6:0]       r_sync2;
    logic [6:0]       r_cand;
    logic [6:0]       r_last;
    logic [CNT_W-1:0] r_cnt;

    logic             w_same;
    logic             w_commit;
    logic             w_new_ev;
    logic             w_drop;
    logic [1:0]       w_kind;
    logic [3:0]       w_val;
    logic [5:0]       w_ev_data;

    assign w_same    = (r_sync2 == r_cand);
    // Commit only on the single edge where the counter reaches its terminal value.
    assign w_commit  = w_same && (r_cnt == TC_PRE);
    assign w_new_ev  = w_commit && (r_cand != r_last);
    assign w_drop    = w_new_ev && ev.EV_VALID && !ev.EV_READY;
    assign w_ev_data = {w_kind, (w_kind == KIND_DIG) ? w_val : 4'h0};

    always_comb begin
        w_kind = KIND_DIG;
        w_val  = 4'h0;
        case (r_cand)
            7'b0000001: w_val = 4'h0;
            7'b1001111: w_val = 4'h1;
            7'b0010010: w_val = 4'h2;
            7'b0000110: w_val = 4'h3;
            7'b1001100: w_val = 4'h4;
            7'b0100100: w_val = 4'h5;
            7'b0100000: w_val = 4'h6;
            7'b0001111: w_val = 4'h7;
            7'b0000000: w_val = 4'h8;
            7'b0000100: w_val = 4'h9;
            7'b0001000: w_val = 4'hA;
            7'b1100000: w_val = 4'hB;
            7'b0110001: w_val = 4'hC;
            7'b1000010: w_val = 4'hD;
            7'b0110000: w_val = 4'hE;
            7'b0111000: w_val = 4'hF;
            SEG_BLANK:  w_kind = KIND_BLK;
            default:    w_kind = KIND_ILL;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_sync1 <= SEG_BLANK;
            r_sync2 <= SEG_BLANK;
            r_cand  <= SEG_BLANK;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= HEX_IN;
            r_sync2 <= r_sync1;
            if (!w_same) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt < TC_LAST) begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_last    <= SEG_BLANK;
            VALUE     <= 4'h0;
            DIG_VALID <= 1'b0;
            BLANK     <= 1'b1;
            ERR       <= 1'b0;
        end else if (w_commit) begin
            r_last    <= r_cand;
            DIG_VALID <= (w_kind == KIND_DIG);
            BLANK     <= (w_kind == KIND_BLK);
            ERR       <= (w_kind == KIND_ILL);
            if (w_kind == KIND_DIG) begin
                VALUE <= w_val;
            end
        end
    end

    // A pending event is only replaced when the consumer takes it on this same edge.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            ev.EV_VALID <= 1'b0;
            ev.EV_DATA  <= 6'h00;
        end else if (w_new_ev && (!ev.EV_VALID || ev.EV_READY)) begin
            ev.EV_VALID <= 1'b1;
            ev.EV_DATA  <= w_ev_data;
        end else if (ev.EV_READY) begin
            ev.EV_VALID <= 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            OVF <= 1'b0;
        end else if (w_drop) begin
            OVF <= 1'b1;
        end else if (CLR_OVF) begin
            OVF <= 1'b0;
        end
    end
endmodule
